rb_word_packer: RTL and testbench
=================================

# rb_word_packer

Downstream stage of `ring_buffer`: drains its byte stream and packs `RATIO` consecutive `IN_W`-bit entries into one wide word for the bus-side consumer. Partial words are emitted with a lane-keep mask on an explicit flush or, optionally, after an input-idle timeout. Valid/ready handshakes are used on both sides; no storage beyond one accumulator and one output register.

## Interface
- `IN_W`, default 8: width of one input entry (ring buffer `data_t` width).
- `RATIO`, default 4: entries per output word; power of two, at least 2.
- `TIMEOUT`, default 16: idle cycles before an automatic partial flush; must be at least 1; used only with `RB_PACK_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  `IN_W`  entry from ring buffer `o_bus.data`.
- `in_valid`  in  1  entry present.
- `in_ready`  out  1  packer accepts the entry this cycle.
- `flush`  in  1  single-cycle request to emit the current partial word.
- `out_data`  out  `IN_W*RATIO`  packed word; the first-accepted entry is in lane 0 (LSBs).
- `out_keep`  out  `RATIO`  lane-valid mask; bit i covers lane i.
- `out_valid`  out  1  word present.
- `out_ready`  in  1  consumer accepts the word.
- `busy`  out  1  accumulator non-empty or a flush is pending.

## Operation
- Handshake: a transfer occurs when valid and ready are both 1 on a rising edge. `out_valid`, `out_data` and `out_keep` stay stable until the word is accepted. `in_ready` is combinational from state and `out_ready`.
- Output slot free: `!out_valid || out_ready`.
- Accumulator: holds the lane count `acc_cnt` (0..RATIO-1) and the lane data.
- States:
  - IDLE: `acc_cnt==0`.
  - FILL: `acc_cnt>0`.
  - FLUSH_PEND: flush requested, output slot busy.
- `in_ready`:
  - 1 in IDLE and FILL, except on the final lane (`acc_cnt==RATIO-1`), where it equals "output slot free".
  - 0 in FLUSH_PEND.
- Accepted entry, non-final lane: written to lane `acc_cnt`; `acc_cnt` increments; IDLE moves to FILL.
- Accepted entry, final lane: the output register loads the full word with `out_keep` all ones. `acc_cnt` returns to 0; state goes to IDLE.
- Flush request: the `flush` pin, or the timeout (below), while in FILL, or in IDLE with an entry accepted in the same cycle.
  - Slot free: the output register loads the accumulator, including any entry accepted that cycle. `out_keep` = `(1<<n)-1`, where n is the lane count; unused lanes are driven 0. Go to IDLE.
  - Slot busy: go to FLUSH_PEND. Emit when the slot frees, then go to IDLE.
- Flush that completes a word: an entry accepted on the final lane in the same cycle as `flush` produces one full word; no extra empty word is emitted.
- Ignored flushes: `flush` in IDLE with no accepted entry, or `flush` in FLUSH_PEND, has no effect.
- `busy` = state != IDLE.

## Timing
- Reset (asynchronous assert, synchronous release by design intent):
  - `out_valid`=0, `out_data`=0, `out_keep`=0, `acc_cnt`=0, state IDLE, timeout counter 0.
  - Hence `in_ready`=1 and `busy`=0.
- Latency: final entry (or flush) accepted at edge N → `out_valid`=1 after edge N, visible in cycle N+1.
- Throughput: one entry per cycle sustained while `out_ready`=1, i.e. one word every `RATIO` cycles.
- Back-pressure: stall only on the final lane or in FLUSH_PEND. The consumer holding `out_ready`=0 for k cycles stalls input at most k cycles.
- Reset mid-operation: accumulated lanes and any pending word are discarded, with no partial emit.
- Counter width: `acc_cnt` is `$clog2(RATIO)` bits. It wraps to 0 only via the final-lane or flush paths.

## Configuration
- `RB_PACK_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT+1)`-bit counter runs in FILL. It clears on every accepted entry and in IDLE.
  - When it reaches `TIMEOUT`, it raises a flush request that cycle, handled exactly like the pin.
  - It holds at `TIMEOUT` while in FLUSH_PEND.
- Not defined: no counter exists, and partial words leave only via the `flush` pin.

## Test plan
- After reset, feed 0xAA, 0xBB, 0xCC, 0xDD back-to-back with `out_ready`=1 → one word 0xDDCCBBAA, keep 0xF, `out_valid` for exactly 1 cycle, cycle after 0xDD accepted.
- Feed 0x11, 0x22, then pulse `flush` → word 0x00002211, keep 0x3; next entry 0x33 lands in lane 0.
- Hold `out_ready`=0 with a full word pending; feed 3 more entries → `in_ready` drops at the 4th lane. Raise `out_ready` → first word drains, then second word completes; no entries lost or duplicated.
- Pulse `flush` in the same cycle as the final lane 0x44 (after 0x11/0x22/0x33) → single word 0x44332211, keep 0xF; `busy`=0 after.
- With `RB_PACK_TIMEOUT_EN`, TIMEOUT=16: feed 0x5A, then idle → word 0x0000005A, keep 0x1, emitted 16 cycles after the accept. Without the macro → no emit after 100 idle cycles.
- Assert `rst_n`=0 with `acc_cnt`=2 and a word pending → all outputs 0 immediately, `in_ready`=1; no stale word after release.

Source files
------------

// File: rtl/rb_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rb_word_packer                                             |
// | Description : Drains the ring_buffer entry stream and packs RATIO        |
// |               consecutive IN_W-bit entries into one wide output word.    |
// |               Partial words leave with a lane-keep mask on an explicit   |
// |               flush or, optionally, after an input-idle timeout.         |
// | Optional    : `define RB_PACK_TIMEOUT_EN enables the idle-timeout flush  |
// |               (counter absent when undefined).                           |
// | Ports       : clk, rst_n      - clock, async active-low reset            |
// |               in_data/valid   - entry from ring buffer                   |
// |               in_ready        - entry accepted this cycle (comb.)        |
// |               flush           - request to emit the partial word         |
// |               out_data/keep   - packed word, lane 0 = first entry        |
// |               out_valid/ready - output handshake                         |
// |               busy            - accumulator non-empty or flush pending   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rb_word_packer #(
  parameter int IN_W    = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int c_cnt_w = $clog2(RATIO);
  // One extra bit so the lane count can express RATIO (a completed word).
  localparam int c_n_w   = c_cnt_w + 1;

  // Elaboration-time guard on the parameter ranges the datapath relies on.
  generate
    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
      $error("rb_word_packer: RATIO must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("rb_word_packer: TIMEOUT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FILL       = 2'd1,
    S_FLUSH_PEND = 2'd2
  } state_t;

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  state_t                         r_state;
  logic [c_cnt_w-1:0]             r_acc_cnt;
  logic [RATIO-1:0][IN_W-1:0]     r_acc;
  logic [RATIO-1:0][IN_W-1:0]     r_out_data;
  logic [RATIO-1:0]               r_out_keep;
  logic                           r_out_valid;

  // ------------------------------------------------------------------------
  // Combinational control
  // ------------------------------------------------------------------------
  logic                           w_slot_free;
  logic                           w_final_lane;
  logic                           w_accept;
  logic                           w_timeout;
  logic                           w_flush_req;
  logic                           w_emit;
  logic [c_n_w-1:0]               w_lanes_next;
  logic [RATIO-1:0][IN_W-1:0]     w_acc_next;
  logic [RATIO-1:0][IN_W-1:0]     w_word_next;
  logic [RATIO-1:0]               w_keep_next;

  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_final_lane = (r_acc_cnt == c_cnt_w'(RATIO - 1));

  // Only the final lane (which would load the output register) and a
  // pending flush ever hold off the producer.
  always_comb begin
    in_ready = 1'b1;
    if (r_state == S_FLUSH_PEND) begin
      in_ready = 1'b0;
    end else if (w_final_lane) begin
      in_ready = w_slot_free;
    end
  end

  assign w_accept = in_valid && in_ready;

  // A flush in IDLE only matters when it arrives together with an entry;
  // a flush in FLUSH_PEND is absorbed by the flush already pending.
  assign w_flush_req = (flush || w_timeout) &&
                       ((r_state == S_FILL) || ((r_state == S_IDLE) && w_accept));

  // Output register loads on: a completed word, a flush with the slot free,
  // or the release of a pending flush. A flush coinciding with the final
  // lane is covered by the completed-word term, so no empty word follows.
  always_comb begin
    w_emit = 1'b0;
    if (r_state == S_FLUSH_PEND) begin
      w_emit = w_slot_free;
    end else begin
      w_emit = (w_accept && w_final_lane) || (w_flush_req && w_slot_free);
    end
  end

  // Accumulator as it would look after this cycle's accepted entry, plus the
  // resulting lane count; both the full-word and partial-word paths use it.
  always_comb begin
    w_acc_next   = r_acc;
    w_lanes_next = {1'b0, r_acc_cnt};
    if (w_accept) begin
      w_acc_next[r_acc_cnt] = in_data;
      w_lanes_next          = {1'b0, r_acc_cnt} + c_n_w'(1);
    end
    for (int i = 0; i < RATIO; i++) begin
      w_keep_next[i] = (c_n_w'(i) < w_lanes_next);
      w_word_next[i] = w_keep_next[i] ? w_acc_next[i] : '0;
    end
  end

  // ------------------------------------------------------------------------
  // Main sequential block
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc_cnt   <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_emit) begin
        r_out_data  <= w_word_next;
        r_out_keep  <= w_keep_next;
        r_out_valid <= 1'b1;
        // Cleared so stale lanes never reach a later partial word.
        r_acc       <= '0;
        r_acc_cnt   <= '0;
        r_state     <= S_IDLE;
      end else if (w_accept) begin
        r_acc     <= w_acc_next;
        r_acc_cnt <= w_lanes_next[c_cnt_w-1:0];
        r_state   <= w_flush_req ? S_FLUSH_PEND : S_FILL;
      end else if (w_flush_req) begin
        // Flush with the output slot still occupied.
        r_state <= S_FLUSH_PEND;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Optional idle-timeout flush
  // ------------------------------------------------------------------------
`ifdef RB_PACK_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT + 1);

  logic [c_to_w-1:0] r_to_cnt;

  // Counts idle FILL cycles, saturating at TIMEOUT; frozen while a flush is
  // pending and cleared once the accumulator empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_emit || w_accept) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt != c_to_w'(TIMEOUT)) begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
          end
        end
        S_FLUSH_PEND: begin
          if (w_emit) begin
            r_to_cnt <= '0;
          end
        end
        default: begin
          r_to_cnt <= '0;
        end
      endcase
    end
  end

  assign w_timeout = (r_state == S_FILL) && (r_to_cnt == c_to_w'(TIMEOUT));
`else
  assign w_timeout = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rb_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rb_word_packer                                          |
// | Description : Directed self-checking bench for rb_word_packer            |
// |               (IN_W=8, RATIO=4, TIMEOUT=16).                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rb_word_packer;

  localparam int IN_W    = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 16;

  logic                  clk;
  logic                  rst_n;
  logic [IN_W-1:0]       in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [IN_W*RATIO-1:0] out_data;
  logic [RATIO-1:0]      out_keep;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  rb_word_packer #(
    .IN_W    (IN_W),
    .RATIO   (RATIO),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for a single edge (caller ensures in_ready=1).
  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    total++; if (out_keep !== 4'h0) begin bad++; $display("FAIL rst_out_keep got=%h exp=0", out_keep); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    step(); step();
    rst_n = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_word();
    logic [7:0] b [4];
    b[0] = 8'hAA; b[1] = 8'hBB; b[2] = 8'hCC; b[3] = 8'hDD;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = b[i];
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_in_ready lane=%0d got=%b exp=1", i, in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid lane=%0d got=%b exp=0", i, out_valid); end
      step();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'hDDCCBBAA) begin bad++; $display("FAIL full_data got=%h exp=DDCCBBAA", out_data); end
    total++; if (out_keep !== 4'hF) begin bad++; $display("FAIL full_keep got=%h exp=F", out_keep); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy got=%b exp=0", busy); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_valid_one_cycle got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    push(8'h11); push(8'h22);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_fill got=%b exp=1", busy); end
    flush = 1'b1; step(); flush = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h00002211) begin bad++; $display("FAIL flush_data got=%h exp=00002211", out_data); end
    total++; if (out_keep !== 4'h3) begin bad++; $display("FAIL flush_keep got=%h exp=3", out_keep); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    step();
    push(8'h33);
    flush = 1'b1; step(); flush = 1'b0;
    total++; if (out_data !== 32'h00000033) begin bad++; $display("FAIL flush_lane0_data got=%h exp=00000033", out_data); end
    total++; if (out_keep !== 4'h1) begin bad++; $display("FAIL flush_lane0_keep got=%h exp=1", out_keep); end
    step();
  endtask

  task automatic test_ignored_flush();
    out_ready = 1'b1;
    flush = 1'b1; step(); flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_flush_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_flush_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    push(8'h01); push(8'h02); push(8'h03);
    in_valid = 1'b1; in_data = 8'h04;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_final got=%b exp=0", in_ready); end
    step();
    total++; if (out_data !== 32'hDDCCBBAA) begin bad++; $display("FAIL bp_hold_data got=%h exp=DDCCBBAA", out_data); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_free got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out_data !== 32'h04030201) begin bad++; $display("FAIL bp_second_data got=%h exp=04030201", out_data); end
    total++; if (out_keep !== 4'hF) begin bad++; $display("FAIL bp_second_keep got=%h exp=F", out_keep); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid got=%b exp=1", out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_third got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush_final();
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    in_valid = 1'b1; in_data = 8'h44; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    total++; if (out_data !== 32'h44332211) begin bad++; $display("FAIL ff_data got=%h exp=44332211", out_data); end
    total++; if (out_keep !== 4'hF) begin bad++; $display("FAIL ff_keep got=%h exp=F", out_keep); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ff_busy got=%b exp=0", busy); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ff_extra_word got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush_pend();
    out_ready = 1'b0;
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    push(8'h77);
    flush = 1'b1; step(); flush = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fp_busy got=%b exp=1", busy); end
    in_valid = 1'b1; in_data = 8'h88;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fp_in_ready got=%b exp=0", in_ready); end
    flush = 1'b1; step(); flush = 1'b0;
    in_valid = 1'b0;
    total++; if (out_data !== 32'hDDCCBBAA) begin bad++; $display("FAIL fp_hold_data got=%h exp=DDCCBBAA", out_data); end
    out_ready = 1'b1;
    step();
    total++; if (out_data !== 32'h00000077) begin bad++; $display("FAIL fp_data got=%h exp=00000077", out_data); end
    total++; if (out_keep !== 4'h1) begin bad++; $display("FAIL fp_keep got=%h exp=1", out_keep); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fp_busy_after got=%b exp=0", busy); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fp_extra_word got=%b exp=0", out_valid); end
  endtask

  task automatic test_timeout();
    int seen;
    int lat;
    seen = 0;
    lat  = 0;
    out_ready = 1'b1;
    push(8'h5A);
`ifdef RB_PACK_TIMEOUT_EN
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    total++; if (lat < TIMEOUT || lat > TIMEOUT + 1) begin bad++; $display("FAIL to_latency got=%0d exp=%0d..%0d", lat, TIMEOUT, TIMEOUT + 1); end
    total++; if (out_data !== 32'h0000005A) begin bad++; $display("FAIL to_data got=%h exp=0000005A", out_data); end
    total++; if (out_keep !== 4'h1) begin bad++; $display("FAIL to_keep got=%h exp=1", out_keep); end
    step();
`else
    repeat (100) begin
      step();
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL to_disabled_emits got=%0d exp=0", seen); end
    flush = 1'b1; step(); flush = 1'b0;
    total++; if (out_data !== 32'h0000005A) begin bad++; $display("FAIL to_manual_data got=%h exp=0000005A", out_data); end
    total++; if (out_keep !== 4'h1) begin bad++; $display("FAIL to_manual_keep got=%h exp=1", out_keep); end
    step();
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    push(8'h01); push(8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rm_data got=%h exp=0", out_data); end
    total++; if (out_keep !== 4'h0) begin bad++; $display("FAIL rm_keep got=%h exp=0", out_keep); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_stale_word got=%b exp=0", out_valid); end
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    total++; if (out_data !== 32'hD4C3B2A1) begin bad++; $display("FAIL rm_clean_data got=%h exp=D4C3B2A1", out_data); end
    total++; if (out_keep !== 4'hF) begin bad++; $display("FAIL rm_clean_keep got=%h exp=F", out_keep); end
    step();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_ignored_flush();
    test_back_to_back();
    test_flush_final();
    test_flush_pend();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
